// File: rtl/ctrl_seq_monitor.sv
// rtl/ctrl_seq_monitor.sv - protocol checker for the FSMController control-strobe output
module ctrl_seq_monitor #(
  parameter int ERR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             mem_rd,
  input  logic             load_ir,
  input  logic             halt,
  input  logic             inc_pc,
  input  logic             load_ac,
  input  logic             load_pc,
  input  logic             mem_wr,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic [2:0]       phase,
  output logic             locked,
  output logic             err,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       err_phase,
  output logic [6:0]       err_got,
  output logic [6:0]       err_exp,
  output logic [CNT_W-1:0] instr_count,
  output logic             halt_seen
);

  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } state_t;

  typedef enum logic [2:0] {
    HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP
  } opcode_t;

  typedef enum logic {MODE_LOCKED, MODE_SEEK} mode_t;

  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             phase_q, phase_nxt;
  mode_t              mode_q, mode_nxt;
  logic               prev_load_ir, prev_load_ir_nxt;
  logic               err_nxt, err_sticky_nxt, halt_seen_nxt;
  logic [ERR_W-1:0]   err_count_nxt;
  logic [2:0]         err_phase_nxt;
  logic [6:0]         err_got_nxt, err_exp_nxt;
  logic [CNT_W-1:0]   instr_count_nxt;
  logic [6:0]         got, expected;
  logic               aluop;
  opcode_t            op;

  assign op     = opcode_t'(opcode);
  assign got    = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
  assign aluop  = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  assign phase  = phase_q;
  assign locked = (mode_q == MODE_LOCKED);

  always_comb begin
    expected = 7'b0000000;
    case (phase_q)
      INST_ADDR:       expected = 7'b0000000;
      INST_FETCH:      expected = 7'b1000000;
      INST_LOAD, IDLE: expected = 7'b1100000;
      OP_ADDR:         expected = (op == HLT) ? 7'b0011000 : 7'b0001000;
      OP_FETCH:        expected = aluop ? 7'b1000000 : 7'b0000000;
      ALU_OP: begin
        if (aluop)                  expected = 7'b1000100;
        else if (op == SKZ && zero) expected = 7'b0001000;
        else if (op == JMP)         expected = 7'b0000010;
      end
      STORE: begin
        if (aluop)           expected = 7'b1000100;
        else if (op == STO)  expected = 7'b0000001;
        else if (op == JMP)  expected = 7'b0000010;
      end
      default:         expected = 7'b0000000;
    endcase
  end

  always_comb begin
    phase_nxt        = phase_q;
    mode_nxt         = mode_q;
    prev_load_ir_nxt = load_ir;
    err_nxt          = 1'b0;
    err_sticky_nxt   = err_sticky;
    err_count_nxt    = err_count;
    err_phase_nxt    = err_phase;
    err_got_nxt      = err_got;
    err_exp_nxt      = err_exp;
    instr_count_nxt  = instr_count;
    halt_seen_nxt    = halt_seen | halt;

    if (mode_q == MODE_LOCKED) begin
      if (got == expected) begin
        phase_nxt = state_t'(phase_q + 3'd1);
        if (phase_q == STORE) instr_count_nxt = instr_count + CNT_ONE;
      end else begin
        err_nxt        = 1'b1;
        err_sticky_nxt = 1'b1;
        mode_nxt       = MODE_SEEK;
        if (err_count != ERR_MAX) err_count_nxt = err_count + ERR_ONE;
        // Only the first mismatch since reset is kept for post-mortem.
        if (!err_sticky) begin
          err_phase_nxt = phase_q;
          err_got_nxt   = got;
          err_exp_nxt   = expected;
        end
      end
    end else if (load_ir && mem_rd && !prev_load_ir) begin
      // Rising load_ir with mem_rd only happens in INST_LOAD, so IDLE follows.
      mode_nxt  = MODE_LOCKED;
      phase_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      phase_q      <= INST_ADDR;
      mode_q       <= MODE_LOCKED;
      prev_load_ir <= 1'b0;
      err          <= 1'b0;
      err_sticky   <= 1'b0;
      err_count    <= '0;
      err_phase    <= '0;
      err_got      <= '0;
      err_exp      <= '0;
      instr_count  <= '0;
      halt_seen    <= 1'b0;
    end else begin
      phase_q      <= phase_nxt;
      mode_q       <= mode_nxt;
      prev_load_ir <= prev_load_ir_nxt;
      err          <= err_nxt;
      err_sticky   <= err_sticky_nxt;
      err_count    <= err_count_nxt;
      err_phase    <= err_phase_nxt;
      err_got      <= err_got_nxt;
      err_exp      <= err_exp_nxt;
      instr_count  <= instr_count_nxt;
      halt_seen    <= halt_seen_nxt;
    end
  end

endmodule

// File: tb/tb_ctrl_seq_monitor.sv
// tb/tb_ctrl_seq_monitor.sv - self-checking bench for ctrl_seq_monitor against a rule-level model
module tb_ctrl_seq_monitor;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic mem_rd = 0, load_ir = 0, halt = 0, inc_pc = 0, load_ac = 0, load_pc = 0, mem_wr = 0;
  logic [2:0] opcode = 3'd0;
  logic zero = 1'b0;

  logic [2:0]  phase, err_phase, phase2, err_phase2;
  logic        locked, err, err_sticky, halt_seen;
  logic        locked2, err2, err_sticky2, halt_seen2;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;
  logic [6:0]  err_got, err_exp, err_got2, err_exp2;
  logic [15:0] instr_count;
  logic [3:0]  instr_count2;

  int errors = 0;
  int checks = 0;

  int       m_phase, m_ec8, m_ec2, m_eph, m_ic16, m_ic4;
  bit       m_locked, m_err, m_sticky, m_halt, m_prev;
  bit [6:0] m_got, m_exp;

  always #5 clk = ~clk;

  ctrl_seq_monitor dut (
    .clk(clk), .rst_(rst_), .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt),
    .inc_pc(inc_pc), .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
    .opcode(opcode), .zero(zero), .phase(phase), .locked(locked), .err(err),
    .err_sticky(err_sticky), .err_count(err_count), .err_phase(err_phase),
    .err_got(err_got), .err_exp(err_exp), .instr_count(instr_count), .halt_seen(halt_seen)
  );

  ctrl_seq_monitor #(.ERR_W(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_(rst_), .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt),
    .inc_pc(inc_pc), .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
    .opcode(opcode), .zero(zero), .phase(phase2), .locked(locked2), .err(err2),
    .err_sticky(err_sticky2), .err_count(err_count2), .err_phase(err_phase2),
    .err_got(err_got2), .err_exp(err_exp2), .instr_count(instr_count2), .halt_seen(halt_seen2)
  );

  // Strobe table the controller must produce, straight from the instruction-cycle rules.
  function automatic bit [6:0] expv(int ph, int op, bit z);
    bit alu;
    alu = (op >= 2 && op <= 5);
    case (ph)
      0: return 7'b0000000;
      1: return 7'b1000000;
      2, 3: return 7'b1100000;
      4: return (op == 0) ? 7'b0011000 : 7'b0001000;
      5: return alu ? 7'b1000000 : 7'b0000000;
      6: return alu ? 7'b1000100 : (op == 1 && z) ? 7'b0001000 : (op == 7) ? 7'b0000010 : 7'b0000000;
      default: return alu ? 7'b1000100 : (op == 6) ? 7'b0000001 : (op == 7) ? 7'b0000010 : 7'b0000000;
    endcase
  endfunction

  task automatic model(input bit [6:0] v, input int op, input bit z, input bit r);
    if (!r) begin
      m_phase = 0; m_locked = 1; m_err = 0; m_sticky = 0; m_halt = 0; m_prev = 0;
      m_ec8 = 0; m_ec2 = 0; m_eph = 0; m_got = 0; m_exp = 0; m_ic16 = 0; m_ic4 = 0;
      return;
    end
    if (v[4]) m_halt = 1;
    m_err = 0;
    if (m_locked) begin
      if (v == expv(m_phase, op, z)) begin
        if (m_phase == 7) begin
          m_ic16 = (m_ic16 + 1) % 65536;
          m_ic4  = (m_ic4 + 1) % 16;
        end
        m_phase = (m_phase + 1) % 8;
      end else begin
        m_err = 1;
        if (m_ec8 < 255) m_ec8++;
        if (m_ec2 < 3) m_ec2++;
        if (!m_sticky) begin
          m_eph = m_phase; m_got = v; m_exp = expv(m_phase, op, z);
        end
        m_sticky = 1;
        m_locked = 0;
      end
    end else if (v[6] && v[5] && !m_prev) begin
      m_locked = 1;
      m_phase = 3;
    end
    m_prev = v[5];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic check_all();
    chk("phase", {29'd0, phase}, m_phase);
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    chk("err_count", {24'd0, err_count}, m_ec8);
    chk("err_phase", {29'd0, err_phase}, m_eph);
    chk("err_got", {25'd0, err_got}, {25'd0, m_got});
    chk("err_exp", {25'd0, err_exp}, {25'd0, m_exp});
    chk("instr_count", {16'd0, instr_count}, m_ic16);
    chk("halt_seen", {31'd0, halt_seen}, {31'd0, m_halt});
    chk("err_count_w2", {30'd0, err_count2}, m_ec2);
    chk("instr_count_w4", {28'd0, instr_count2}, m_ic4);
    chk("locked_w2", {31'd0, locked2}, {31'd0, m_locked});
  endtask

  task automatic step(input bit [6:0] v, input int op, input bit z, input bit r);
    {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = v;
    opcode = op[2:0];
    zero = z;
    rst_ = r;
    @(posedge clk);
    model(v, op, z, r);
    #1;
    check_all();
  endtask

  // One controller instruction; optionally one phase is corrupted or reset is asserted there.
  task automatic run_instr(input int op, input bit z, input int bad_ph, input bit [6:0] bad_v,
                           input int rst_ph);
    for (int ph = 0; ph < 8; ph++) begin
      if (ph == rst_ph) begin
        step(expv(ph, op, z), op, z, 1'b0);
        return;
      end
      step((ph == bad_ph) ? bad_v : expv(ph, op, z), op, z, 1'b1);
    end
  endtask

  initial begin
    step(7'b0, 0, 0, 1'b0);
    step(7'b0, 0, 0, 1'b0);
    chk("reset_phase", {29'd0, phase}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd1);

    run_instr(2, 0, -1, 7'b0, -1);
    chk("add_instr_count", {16'd0, instr_count}, 32'd1);
    chk("add_phase", {29'd0, phase}, 32'd0);

    run_instr(1, 1, 6, 7'b0000000, -1);
    chk("skz_err_count", {24'd0, err_count}, 32'd1);
    chk("skz_err_phase", {29'd0, err_phase}, 32'd6);
    chk("skz_err_exp", {25'd0, err_exp}, 32'b0001000);
    chk("skz_unlocked", {31'd0, locked}, 32'd0);

    run_instr(2, 0, -1, 7'b0, -1);
    chk("relock", {31'd0, locked}, 32'd1);
    chk("relock_instr_count", {16'd0, instr_count}, 32'd2);

    for (int k = 0; k < 4; k++) begin
      run_instr(4, 0, 5, 7'b0000000, -1);
      run_instr(7, 0, -1, 7'b0, -1);
    end
    chk("sat_err_count_w2", {30'd0, err_count2}, 32'd3);
    chk("err_count_5", {24'd0, err_count}, 32'd5);
    chk("first_capture_kept", {29'd0, err_phase2}, 32'd6);

    step(7'b0, 0, 0, 1'b0);
    run_instr(0, 0, -1, 7'b0, -1);
    run_instr(6, 0, -1, 7'b0, -1);
    chk("hlt_halt_seen", {31'd0, halt_seen}, 32'd1);
    chk("hlt_sto_instr_count", {16'd0, instr_count}, 32'd2);
    chk("hlt_sto_no_err", {31'd0, err_sticky}, 32'd0);

    run_instr(3, 0, 1, 7'b1111111, -1);
    run_instr(5, 1, -1, 7'b0, 5);
    chk("rst_phase", {29'd0, phase}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd1);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_instr_count", {16'd0, instr_count}, 32'd0);

    for (int k = 0; k < 17; k++) run_instr(2, 0, -1, 7'b0, -1);
    chk("wrap_instr_count_w4", {28'd0, instr_count2}, 32'd1);
    chk("instr_count_17", {16'd0, instr_count}, 32'd17);

    for (int k = 0; k < 80; k++) begin
      int op, bad_ph, rst_ph;
      bit z;
      bit [6:0] bad_v;
      op = $urandom_range(0, 7);
      z = 1'($urandom_range(0, 1));
      bad_ph = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : -1;
      bad_v = 7'($urandom);
      rst_ph = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 7) : -1;
      run_instr(op, z, bad_ph, bad_v, rst_ph);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
